// File: rtl/pair_mean.sv
// pair_mean: pipelined floor((a + b) / 2) of two signed or unsigned operands
module pair_mean #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             input_strobe,
    output logic [WIDTH-1:0] c,
    output logic             output_strobe
);
    logic [WIDTH-1:0] a0, b0;
    logic             sign0, valid0;
    logic [WIDTH:0]   ext_a, ext_b, sum1;
    logic             valid1;
    logic             accept;

    assign accept = input_strobe & enable;

    // Widen captured operands by one bit; the MSB copies the operand sign only in signed mode
    always_comb begin
        ext_a = {sign0 & a0[WIDTH-1], a0};
        ext_b = {sign0 & b0[WIDTH-1], b0};
    end

    // Capture operands only on accept so idle-bus X never reaches the datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            a0     <= '0;
            b0     <= '0;
            sign0  <= 1'b0;
            valid0 <= 1'b0;
        end else begin
            valid0 <= accept;
            if (accept) begin
                a0    <= a;
                b0    <= b;
                sign0 <= sign;
            end
        end
    end

    // Full-width sum; the extra bit makes overflow impossible in either mode
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sum1   <= '0;
            valid1 <= 1'b0;
        end else begin
            valid1 <= valid0;
            if (valid0) sum1 <= ext_a + ext_b;
        end
    end

    // Arithmetic shift of the widened sum gives floor rounding; c holds between strobes
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c             <= '0;
            output_strobe <= 1'b0;
        end else begin
            output_strobe <= valid1;
            if (valid1) c <= WIDTH'(sum1 >> 1);
        end
    end
endmodule

// File: tb/tb_pair_mean.sv
// tb_pair_mean: directed-vector checks of pair_mean results, latency and control corners
module tb_pair_mean;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic        sign = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        input_strobe = 1'b0;
    logic [15:0] c;
    logic        output_strobe;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    logic        vs [8];
    logic [15:0] va [8];
    logic [15:0] vb [8];
    logic [15:0] ve [8];
    int          acc_t [8];
    logic [15:0] got_c [$];
    int          got_t [$];

    pair_mean #(.WIDTH(16)) dut (
        .clock(clock), .reset(reset), .enable(enable), .sign(sign),
        .a(a), .b(b), .input_strobe(input_strobe),
        .c(c), .output_strobe(output_strobe)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (output_strobe) begin
            got_c.push_back(c);
            got_t.push_back(cyc);
        end
    end

    task automatic burst(input int n);
        got_c.delete();
        got_t.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            sign = vs[i];
            a = va[i];
            b = vb[i];
            input_strobe = 1'b1;
            @(posedge clock);
            #1 acc_t[i] = cyc;
        end
        @(negedge clock);
        input_strobe = 1'b0;
        a = 'x;
        b = 'x;
        repeat (5) @(negedge clock);
    endtask

    task automatic score(input string name, input int n);
        vectors++;
        if (got_c.size() !== n) begin
            miscompares++;
            $display("FAIL %s count: got %0d strobes, want %0d", name, got_c.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                vectors++;
                if (got_c[i] !== ve[i] || got_t[i] - acc_t[i] !== 2) begin
                    miscompares++;
                    $display("FAIL %s[%0d]: got c=%h lat=%0d, want c=%h lat=2",
                             name, i, got_c[i], got_t[i] - acc_t[i], ve[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        input_strobe = 1'b1;
        a = 16'h1234;
        b = 16'h4321;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            vectors++;
            if (c !== 16'h0 || output_strobe !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_hold: got c=%h strobe=%b, want c=0000 strobe=0", c, output_strobe);
            end
        end
        input_strobe = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            if (output_strobe !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_idle: got strobe=%b, want 0", output_strobe);
            end
        end
    endtask

    task automatic test_signed_basic;
        vs[0] = 1; va[0] = 16'hFFE1; vb[0] = 16'h000B; ve[0] = 16'hFFF6;
        vs[1] = 1; va[1] = 16'h000B; vb[1] = 16'h0015; ve[1] = 16'h0010;
        burst(1);
        score("signed_a", 1);
        vs[0] = vs[1]; va[0] = va[1]; vb[0] = vb[1]; ve[0] = ve[1];
        burst(1);
        score("signed_b", 1);
        vectors++;
        if (c !== 16'h0010) begin
            miscompares++;
            $display("FAIL hold: got c=%h, want 0010", c);
        end
    endtask

    task automatic test_unsigned;
        vs[0] = 0; va[0] = 16'hFFE1; vb[0] = 16'h000B; ve[0] = 16'h7FF6;
        vs[1] = 0; va[1] = 16'hFFFF; vb[1] = 16'hFFFF; ve[1] = 16'hFFFF;
        burst(2);
        score("unsigned", 2);
    endtask

    task automatic test_extremes;
        vs[0] = 1; va[0] = 16'hFFFD; vb[0] = 16'h0000; ve[0] = 16'hFFFE;
        vs[1] = 1; va[1] = 16'h0003; vb[1] = 16'h0000; ve[1] = 16'h0001;
        vs[2] = 1; va[2] = 16'h8000; vb[2] = 16'h8000; ve[2] = 16'h8000;
        vs[3] = 1; va[3] = 16'h7FFF; vb[3] = 16'h7FFF; ve[3] = 16'h7FFF;
        vs[4] = 1; va[4] = 16'h8000; vb[4] = 16'h7FFF; ve[4] = 16'hFFFF;
        burst(5);
        score("extremes", 5);
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) begin
            vs[i] = (i % 2 == 0);
            va[i] = 16'hFFFE;
            vb[i] = 16'h0000;
            ve[i] = (i % 2 == 0) ? 16'hFFFF : 16'h7FFF;
        end
        burst(4);
        score("stream", 4);
        vectors++;
        if (got_t.size() == 4 && got_t[3] - got_t[0] !== 3) begin
            miscompares++;
            $display("FAIL stream_gap: got span %0d, want 3", got_t[3] - got_t[0]);
        end
    endtask

    task automatic test_enable;
        got_c.delete();
        @(negedge clock);
        enable = 1'b0;
        input_strobe = 1'b1;
        sign = 1'b0;
        a = 16'h0100;
        b = 16'h0200;
        @(negedge clock);
        input_strobe = 1'b0;
        enable = 1'b1;
        repeat (5) @(negedge clock);
        vectors++;
        if (got_c.size() !== 0) begin
            miscompares++;
            $display("FAIL enable_block: got %0d strobes, want 0", got_c.size());
        end
        got_c.delete();
        a = 16'h0004;
        b = 16'h0006;
        input_strobe = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        a = 16'h0400;
        b = 16'h0600;
        @(negedge clock);
        input_strobe = 1'b0;
        repeat (5) @(negedge clock);
        enable = 1'b1;
        vectors++;
        if (got_c.size() !== 1 || c !== 16'h0005) begin
            miscompares++;
            $display("FAIL enable_inflight: got %0d strobes c=%h, want 1 strobe c=0005", got_c.size(), c);
        end
    endtask

    task automatic test_reset_midflight;
        got_c.delete();
        @(negedge clock);
        sign = 1'b0;
        a = 16'h0010;
        b = 16'h0030;
        input_strobe = 1'b1;
        @(negedge clock);
        input_strobe = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        repeat (5) @(negedge clock);
        vectors++;
        if (got_c.size() !== 0 || c !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_flush: got %0d strobes c=%h, want 0 strobes c=0000", got_c.size(), c);
        end
    endtask

    initial begin
        test_reset();
        test_signed_basic();
        test_unsigned();
        test_extremes();
        test_back_to_back();
        test_enable();
        test_reset_midflight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
